ps2_key_tracker: RTL and testbench

Multi-key PS/2 scan-code tracker that sits directly behind PS2_Controller and consumes its received_data/received_data_en byte stream. It decodes set-2 make, break (F0) and extended (E0) sequences against a parametrised key table, and keeps a held-state bit per tracked key. It emits one-cycle press/release events and resolves a 2-bit accel command with last-pressed-wins priority between keys 0 and 1. It replaces single-key decoding and adds multi-key, extended-code, typematic-filter and stall-recovery behaviour.

---
 rtl/ps2_key_tracker.sv | 166 ++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// Purpose : decode set-2 PS/2 make/break/E0 sequences into held-state bits for a table of keys.
// Latency : key_held/key_event/event_* 1 cycle after the final byte strobe; accel 1 cycle after key_held.
// Backpressure: none, every received_data_en strobe is consumed in the cycle it arrives.
//
// Ports:
//   CLOCK_50          system clock, all logic on posedge
//   resetn            synchronous active-low reset
//   received_data     byte from PS2_Controller, valid when received_data_en=1
//   received_data_en  one-cycle byte strobe
//   key_held          bit i = table key i currently held
//   key_event         one-cycle pulse on a held-state change
//   event_index       table index of the most recent event (holds between events)
//   event_is_make     1 = press, 0 = release for the most recent event
//   accel             10 forward (key 0), 01 backward (key 1), 00 idle
//   seq_error         one-cycle pulse when a partial sequence is abandoned on timeout
module ps2_key_tracker #(
   parameter int                    NUM_KEYS       = 4,
   parameter logic [9*NUM_KEYS-1:0] KEY_CODES      = {9'h074, 9'h06B, 9'h072, 9'h073},
   parameter int                    TIMEOUT_CYCLES = 50000,
   parameter int                    IDX_W          = 4
) (
   input  logic                CLOCK_50,
   input  logic                resetn,
   input  logic [7:0]          received_data,
   input  logic                received_data_en,
   output logic [NUM_KEYS-1:0] key_held,
   output logic                key_event,
   output logic [IDX_W-1:0]    event_index,
   output logic                event_is_make,
   output logic [1:0]          accel,
   output logic                seq_error
);

   localparam int SEL_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXT,
      S_BRK,
      S_EXT_BRK
   } state_t;

   state_t           state;
   state_t           nxt_state;
   logic [CNT_W-1:0] tmo_cnt;
   logic             last_dir;   // 0 = key 0 pressed most recently, 1 = key 1

   // Byte decode for the current state.
   logic do_make;
   logic do_break;
   logic lk_ext;
   logic clr_all;

   always_comb begin
      nxt_state = state;
      do_make   = 1'b0;
      do_break  = 1'b0;
      lk_ext    = 1'b0;
      clr_all   = 1'b0;
      case (state)
         S_IDLE: begin
            case (received_data)
               8'hE0:                     nxt_state = S_EXT;
               8'hF0:                     nxt_state = S_BRK;
               // BAT result / error / buffer overrun codes: keyboard state is unknown
               8'hAA, 8'hFC, 8'h00, 8'hFF: clr_all  = 1'b1;
               default:                   do_make   = 1'b1;
            endcase
         end
         S_EXT: begin
            if (received_data == 8'hF0) begin
               nxt_state = S_EXT_BRK;
            end else if (received_data == 8'hE0) begin
               nxt_state = S_EXT;
            end else begin
               do_make   = 1'b1;
               lk_ext    = 1'b1;
               nxt_state = S_IDLE;
            end
         end
         S_BRK: begin
            do_break  = 1'b1;
            nxt_state = S_IDLE;
         end
         S_EXT_BRK: begin
            do_break  = 1'b1;
            lk_ext    = 1'b1;
            nxt_state = S_IDLE;
         end
      endcase
   end

   // Table lookup; scanning downward lets the lowest matching index win.
   logic             hit;
   logic [SEL_W-1:0] hit_sel;

   always_comb begin
      hit     = 1'b0;
      hit_sel = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (KEY_CODES[9*i +: 9] == {lk_ext, received_data}) begin
            hit     = 1'b1;
            hit_sel = SEL_W'(i);
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state         <= S_IDLE;
         tmo_cnt       <= '0;
         last_dir      <= 1'b0;
         key_held      <= '0;
         key_event     <= 1'b0;
         event_index   <= '0;
         event_is_make <= 1'b0;
         accel         <= 2'b00;
         seq_error     <= 1'b0;
      end else begin
         key_event <= 1'b0;
         seq_error <= 1'b0;

         // accel follows the registered key_held, so it trails it by one cycle.
         case (key_held[1:0])
            2'b01:   accel <= 2'b10;
            2'b10:   accel <= 2'b01;
            2'b11:   accel <= last_dir ? 2'b01 : 2'b10;
            default: accel <= 2'b00;
         endcase

         if (received_data_en) begin
            tmo_cnt <= '0;
            state   <= nxt_state;
            if (clr_all) begin
               key_held <= '0;
            end else if (hit && do_make && !key_held[hit_sel]) begin
               key_held[hit_sel] <= 1'b1;
               key_event         <= 1'b1;
               event_index       <= IDX_W'(hit_sel);
               event_is_make     <= 1'b1;
               if (hit_sel == SEL_W'(0)) last_dir <= 1'b0;
               else if (hit_sel == SEL_W'(1)) last_dir <= 1'b1;
            end else if (hit && do_break && key_held[hit_sel]) begin
               key_held[hit_sel] <= 1'b0;
               key_event         <= 1'b1;
               event_index       <= IDX_W'(hit_sel);
               event_is_make     <= 1'b0;
            end
            // Typematic repeats and breaks of unheld keys fall through silently.
         end else if (state != S_IDLE) begin
            if (tmo_cnt == CNT_LAST) begin
               state     <= S_IDLE;
               seq_error <= 1'b1;
               tmo_cnt   <= '0;
            end else begin
               tmo_cnt <= tmo_cnt + 1'b1;
            end
         end else begin
            tmo_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Purpose : self-checking bench for ps2_key_tracker (directed table, corner sequences, random vs model).
// Latency : outputs sampled on the negedge after the strobe-capturing posedge.
// Backpressure: none, strobes are driven freely.
module tb_ps2_key_tracker;

   localparam int NK  = 4;
   localparam int TMO = 40;
   localparam int IW  = 4;
   // Key 3 is the E0-extended 74 so the extended path has a table entry.
   localparam logic [9*NK-1:0] KC = {9'h174, 9'h06B, 9'h072, 9'h073};

   logic          clk = 1'b0;
   logic          resetn;
   logic [7:0]    rx_data;
   logic          rx_en;
   logic [NK-1:0] key_held;
   logic          key_event;
   logic [IW-1:0] event_index;
   logic          event_is_make;
   logic [1:0]    accel;
   logic          seq_error;

   ps2_key_tracker #(
      .NUM_KEYS(NK), .KEY_CODES(KC), .TIMEOUT_CYCLES(TMO), .IDX_W(IW)
   ) dut (
      .CLOCK_50(clk), .resetn(resetn),
      .received_data(rx_data), .received_data_en(rx_en),
      .key_held(key_held), .key_event(key_event), .event_index(event_index),
      .event_is_make(event_is_make), .accel(accel), .seq_error(seq_error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_en   = 1'b1;
      @(negedge clk);
      rx_en   = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [7:0]    b;
      logic [NK-1:0] held;
      logic          ev;
      logic [IW-1:0] idx;
      logic          mk;
      logic [1:0]    acc;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t v(input logic [7:0] b, input logic [3:0] held, input logic ev,
                              input logic [3:0] idx, input logic mk, input logic [1:0] acc);
      vec_t r;
      r.b = b; r.held = held; r.ev = ev; r.idx = idx; r.mk = mk; r.acc = acc;
      return r;
   endfunction

   // ---------------- reference model ----------------
   logic [8:0]    tbl [NK];
   logic [NK-1:0] m_held;
   logic          m_ext, m_brk;
   logic [IW-1:0] m_idx;
   logic          m_mk;
   int            t_press [2];
   int            tick;

   task automatic model_clear();
      m_held = '0; m_ext = 1'b0; m_brk = 1'b0; m_idx = '0; m_mk = 1'b0;
      t_press[0] = 0; t_press[1] = 0; tick = 0;
   endtask

   // Interprets one byte by the prefix rules; returns whether an event results.
   task automatic model_byte(input logic [7:0] b, output logic ev);
      int hit;
      ev = 1'b0;
      if (!m_brk && b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (!m_brk && b == 8'hF0) begin
         m_brk = 1'b1;
      end else if (!m_ext && !m_brk && (b == 8'hAA || b == 8'hFC || b == 8'h00 || b == 8'hFF)) begin
         m_held = '0;
      end else begin
         hit = -1;
         for (int i = 0; i < NK; i++)
            if (hit < 0 && tbl[i] == {m_ext, b}) hit = i;
         if (hit >= 0) begin
            if (!m_brk && !m_held[hit]) begin
               m_held[hit] = 1'b1; ev = 1'b1; m_mk = 1'b1; m_idx = IW'(hit);
               if (hit < 2) begin tick++; t_press[hit] = tick; end
            end else if (m_brk && m_held[hit]) begin
               m_held[hit] = 1'b0; ev = 1'b1; m_mk = 1'b0; m_idx = IW'(hit);
            end
         end
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   function automatic logic [1:0] model_accel();
      if (m_held[0] && m_held[1]) return (t_press[0] > t_press[1]) ? 2'b10 : 2'b01;
      if (m_held[0]) return 2'b10;
      if (m_held[1]) return 2'b01;
      return 2'b00;
   endfunction

   logic [7:0] pool [10];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       en, ev_exp;
      logic [7:0] b;
      logic [1:0] acc_exp;
      int         idle_run, n_se, first_k;

      tbl[0] = 9'h073; tbl[1] = 9'h072; tbl[2] = 9'h06B; tbl[3] = 9'h174;
      pool[0] = 8'h73; pool[1] = 8'h72; pool[2] = 8'h6B; pool[3] = 8'h74; pool[4] = 8'hE0;
      pool[5] = 8'hF0; pool[6] = 8'hAA; pool[7] = 8'h12; pool[8] = 8'h73; pool[9] = 8'hF0;

      resetn = 1'b0; rx_en = 1'b0; rx_data = 8'h00;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      chk("rst_held",  32'(key_held), 0);
      chk("rst_event", 32'(key_event), 0);
      chk("rst_idx",   32'(event_index), 0);
      chk("rst_mk",    32'(event_is_make), 0);
      chk("rst_accel", 32'(accel), 0);
      chk("rst_seqerr", 32'(seq_error), 0);

      // single key press/release
      vt.push_back(v(8'h73, 4'b0001, 1, 0, 1, 2'b10));
      vt.push_back(v(8'hF0, 4'b0001, 0, 0, 0, 2'b10));
      vt.push_back(v(8'h73, 4'b0000, 1, 0, 0, 2'b00));
      // last pressed wins, fallback to held key
      vt.push_back(v(8'h73, 4'b0001, 1, 0, 1, 2'b10));
      vt.push_back(v(8'h72, 4'b0011, 1, 1, 1, 2'b01));
      vt.push_back(v(8'hF0, 4'b0011, 0, 0, 0, 2'b01));
      vt.push_back(v(8'h72, 4'b0001, 1, 1, 0, 2'b10));
      vt.push_back(v(8'hF0, 4'b0001, 0, 0, 0, 2'b10));
      vt.push_back(v(8'h73, 4'b0000, 1, 0, 0, 2'b00));
      // extended code vs plain code
      vt.push_back(v(8'hE0, 4'b0000, 0, 0, 0, 2'b00));
      vt.push_back(v(8'h74, 4'b1000, 1, 3, 1, 2'b00));
      vt.push_back(v(8'h74, 4'b1000, 0, 0, 0, 2'b00));
      vt.push_back(v(8'hE0, 4'b1000, 0, 0, 0, 2'b00));
      vt.push_back(v(8'hF0, 4'b1000, 0, 0, 0, 2'b00));
      vt.push_back(v(8'h74, 4'b0000, 1, 3, 0, 2'b00));
      // typematic repeat
      vt.push_back(v(8'h73, 4'b0001, 1, 0, 1, 2'b10));
      for (int i = 0; i < 4; i++) vt.push_back(v(8'h73, 4'b0001, 0, 0, 0, 2'b10));
      vt.push_back(v(8'hF0, 4'b0001, 0, 0, 0, 2'b10));
      vt.push_back(v(8'h73, 4'b0000, 1, 0, 0, 2'b00));
      // key 1 first, then key 0; release key 0 falls back to key 1
      vt.push_back(v(8'h72, 4'b0010, 1, 1, 1, 2'b01));
      vt.push_back(v(8'h73, 4'b0011, 1, 0, 1, 2'b10));
      vt.push_back(v(8'hF0, 4'b0011, 0, 0, 0, 2'b10));
      vt.push_back(v(8'h73, 4'b0010, 1, 0, 0, 2'b01));
      vt.push_back(v(8'hF0, 4'b0010, 0, 0, 0, 2'b01));
      vt.push_back(v(8'h72, 4'b0000, 1, 1, 0, 2'b00));
      // non-accel key and clear codes
      vt.push_back(v(8'h6B, 4'b0100, 1, 2, 1, 2'b00));
      vt.push_back(v(8'h73, 4'b0101, 1, 0, 1, 2'b10));
      vt.push_back(v(8'hAA, 4'b0000, 0, 0, 0, 2'b00));
      vt.push_back(v(8'h73, 4'b0001, 1, 0, 1, 2'b10));
      vt.push_back(v(8'hFF, 4'b0000, 0, 0, 0, 2'b00));

      foreach (vt[i]) begin
         send_byte(vt[i].b);
         chk($sformatf("vec%0d_held", i), 32'(key_held), 32'(vt[i].held));
         chk($sformatf("vec%0d_event", i), 32'(key_event), 32'(vt[i].ev));
         if (vt[i].ev) begin
            chk($sformatf("vec%0d_idx", i), 32'(event_index), 32'(vt[i].idx));
            chk($sformatf("vec%0d_mk", i), 32'(event_is_make), 32'(vt[i].mk));
         end
         @(negedge clk);
         chk($sformatf("vec%0d_accel", i), 32'(accel), 32'(vt[i].acc));
         chk($sformatf("vec%0d_pulse", i), 32'(key_event), 0);
      end

      // partial sequence timeout
      send_byte(8'hE0);
      n_se = 0; first_k = 0;
      for (int k = 1; k <= TMO + 20; k++) begin
         @(negedge clk);
         if (seq_error) begin
            n_se++;
            if (first_k == 0) first_k = k;
         end
      end
      chk("timeout_pulses", 32'(n_se), 1);
      chk("timeout_cycle", 32'(first_k), 32'(TMO));
      send_byte(8'h73);
      chk("post_tmo_event", 32'(key_event), 1);
      chk("post_tmo_idx", 32'(event_index), 0);
      chk("post_tmo_mk", 32'(event_is_make), 1);
      chk("post_tmo_held", 32'(key_held), 32'(4'b0001));
      send_byte(8'hF0);
      send_byte(8'h73);
      chk("post_tmo_release", 32'(key_held), 0);

      // reset in the middle of a break sequence
      send_byte(8'h73);
      send_byte(8'h72);
      chk("pre_rst_held", 32'(key_held), 32'(4'b0011));
      send_byte(8'hF0);
      do_reset();
      chk("midrst_held", 32'(key_held), 0);
      chk("midrst_event", 32'(key_event), 0);
      chk("midrst_idx", 32'(event_index), 0);
      chk("midrst_mk", 32'(event_is_make), 0);
      chk("midrst_accel", 32'(accel), 0);
      chk("midrst_seqerr", 32'(seq_error), 0);
      send_byte(8'h72);
      chk("postrst_event", 32'(key_event), 1);
      chk("postrst_idx", 32'(event_index), 1);
      chk("postrst_mk", 32'(event_is_make), 1);
      chk("postrst_held", 32'(key_held), 32'(4'b0010));
      @(negedge clk);
      chk("postrst_accel", 32'(accel), 32'(2'b01));

      // random stream, strobes sometimes on consecutive cycles
      do_reset();
      model_clear();
      idle_run = 0;
      for (int c = 0; c < 1500; c++) begin
         en = ($urandom_range(0, 2) == 0) || (idle_run >= 15);
         b  = pool[$urandom_range(0, 9)];
         idle_run = en ? 0 : idle_run + 1;
         rx_en   = en;
         rx_data = b;
         @(negedge clk);
         acc_exp = model_accel();
         ev_exp  = 1'b0;
         if (en) model_byte(b, ev_exp);
         chk("rnd_held", 32'(key_held), 32'(m_held));
         chk("rnd_event", 32'(key_event), 32'(ev_exp));
         chk("rnd_idx", 32'(event_index), 32'(m_idx));
         chk("rnd_mk", 32'(event_is_make), 32'(m_mk));
         chk("rnd_accel", 32'(accel), 32'(acc_exp));
         chk("rnd_seqerr", 32'(seq_error), 0);
      end
      rx_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
